// File: rtl/mig_req_arb.sv
// Purpose: round-robin arbiter sharing one MIG req/wdq pair between two line ports, with an in-order read-tag FIFO steering rdq data back.
// Latency: command ack is combinational (0 cycles) when eligible; read data appears on pX_rvalid one cycle after the rdq pop.
// Backpressure: a port stays unacked while req/wdq is full or the tag FIFO is full; rdq is always drained when non-empty.
module mig_req_arb #(
  parameter int TAG_DEPTH = 8,
  parameter int TAG_AW    = 3
) (
  input  logic         mclk,
  input  logic         mrst_n,
  input  logic         p0_req,
  input  logic         p0_rd_bwt,
  input  logic [31:0]  p0_addr,
  input  logic [15:0]  p0_wmask,
  input  logic [127:0] p0_wdata,
  output logic         p0_ack,
  output logic         p0_rvalid,
  output logic [127:0] p0_rdata,
  input  logic         p1_req,
  input  logic         p1_rd_bwt,
  input  logic [31:0]  p1_addr,
  input  logic [15:0]  p1_wmask,
  input  logic [127:0] p1_wdata,
  output logic         p1_ack,
  output logic         p1_rvalid,
  output logic [127:0] p1_rdata,
  output logic         req_wen,
  output logic [31:0]  req_waddr,
  output logic         req_wrd_bwt,
  input  logic         req_wqfull,
  output logic         wdq_wen,
  output logic [143:0] wdq_mask_wdata,
  input  logic         wdq_wqfull,
  output logic         rdq_rnext,
  input  logic         rdq_rqempty,
  input  logic [127:0] rdq_rdata,
  output logic         arb_err
);

  localparam logic [TAG_AW:0] LP_TAG_FULL = (TAG_AW+1)'(TAG_DEPTH);

  logic                 r_last_grant;
  logic [TAG_DEPTH-1:0] r_tag_mem;
  logic [TAG_AW-1:0]    r_wptr;
  logic [TAG_AW-1:0]    r_rptr;
  logic [TAG_AW:0]      r_tag_cnt;
  logic                 r_p0_rvalid;
  logic                 r_p1_rvalid;
  logic [127:0]         r_p0_rdata;
  logic [127:0]         r_p1_rdata;
  logic                 r_arb_err;

  logic w_tag_full;
  logic w_tag_empty;
  logic w_p0_el;
  logic w_p1_el;
  logic w_g0;
  logic w_g1;
  logic w_grant;
  logic w_gnt_rd;
  logic w_rdq_pop;
  logic w_tag_pop;
  logic w_tag_push;
  logic w_orphan;
  logic w_tag_head;

  // Eligibility uses the pre-pop tag count, so a full FIFO blocks a read even when a pop lands in the same cycle.
  assign w_tag_full  = (r_tag_cnt == LP_TAG_FULL);
  assign w_tag_empty = (r_tag_cnt == '0);

  // Outputs are held quiet while reset is asserted, since acks and pops are combinational.
  assign w_p0_el = mrst_n & p0_req & ~req_wqfull & (p0_rd_bwt ? ~w_tag_full : ~wdq_wqfull);
  assign w_p1_el = mrst_n & p1_req & ~req_wqfull & (p1_rd_bwt ? ~w_tag_full : ~wdq_wqfull);

  // On a tie the port that did not win last time goes; a lone eligible port always wins.
  assign w_g0     = w_p0_el & (~w_p1_el |  r_last_grant);
  assign w_g1     = w_p1_el & (~w_p0_el | ~r_last_grant);
  assign w_grant  = w_g0 | w_g1;
  assign w_gnt_rd = w_g1 ? p1_rd_bwt : p0_rd_bwt;

  assign p0_ack         = w_g0;
  assign p1_ack         = w_g1;
  assign req_wen        = w_grant;
  assign req_waddr      = w_g1 ? p1_addr : p0_addr;
  assign req_wrd_bwt    = w_gnt_rd;
  assign wdq_wen        = w_grant & ~w_gnt_rd;
  assign wdq_mask_wdata = w_g1 ? {p1_wmask, p1_wdata} : {p0_wmask, p0_wdata};

  // rdq is always drained; entries with no matching tag are orphans and only flag an error.
  assign w_rdq_pop  = mrst_n & ~rdq_rqempty;
  assign w_tag_pop  = w_rdq_pop & ~w_tag_empty;
  assign w_orphan   = w_rdq_pop & w_tag_empty;
  assign w_tag_push = w_grant & w_gnt_rd;
  assign w_tag_head = r_tag_mem[r_rptr];
  assign rdq_rnext  = w_rdq_pop;

  assign p0_rvalid = r_p0_rvalid;
  assign p1_rvalid = r_p1_rvalid;
  assign p0_rdata  = r_p0_rdata;
  assign p1_rdata  = r_p1_rdata;
  assign arb_err   = r_arb_err;

  // Round-robin pointer: remembers which port won the most recent grant.
  always_ff @(posedge mclk or negedge mrst_n) begin
    if (!mrst_n) begin
      r_last_grant <= 1'b1;
    end else if (w_grant) begin
      r_last_grant <= w_g1;
    end
  end

  // In-order tag FIFO holding the issuing port of each outstanding read.
  always_ff @(posedge mclk or negedge mrst_n) begin
    if (!mrst_n) begin
      r_tag_mem <= '0;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_tag_cnt <= '0;
    end else begin
      if (w_tag_push) begin
        r_tag_mem[r_wptr] <= w_g1;
        r_wptr            <= r_wptr + 1'b1;
      end
      if (w_tag_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_tag_push, w_tag_pop})
        2'b10:   r_tag_cnt <= r_tag_cnt + 1'b1;
        2'b01:   r_tag_cnt <= r_tag_cnt - 1'b1;
        default: r_tag_cnt <= r_tag_cnt;
      endcase
    end
  end

  // Steer popped rdq data to the tagged port; the data registers hold between returns.
  always_ff @(posedge mclk or negedge mrst_n) begin
    if (!mrst_n) begin
      r_p0_rvalid <= 1'b0;
      r_p1_rvalid <= 1'b0;
      r_p0_rdata  <= '0;
      r_p1_rdata  <= '0;
    end else begin
      r_p0_rvalid <= w_tag_pop & ~w_tag_head;
      r_p1_rvalid <= w_tag_pop &  w_tag_head;
      if (w_tag_pop & ~w_tag_head) begin
        r_p0_rdata <= rdq_rdata;
      end
      if (w_tag_pop & w_tag_head) begin
        r_p1_rdata <= rdq_rdata;
      end
    end
  end

  // Sticky error: read data arrived with no read outstanding.
  always_ff @(posedge mclk or negedge mrst_n) begin
    if (!mrst_n) begin
      r_arb_err <= 1'b0;
    end else if (w_orphan) begin
      r_arb_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mig_req_arb.sv
// Purpose: scoreboard bench for mig_req_arb; a port/queue-level model predicts grants, rdq pops and read returns.
// Latency: expectations are queued at stimulus time and consumed by an independent monitor mid-cycle.
// Backpressure: req/wdq full flags and rdq return timing are driven by the bench, directed then randomized.
module tb_mig_req_arb;

  logic         mclk = 1'b0;
  logic         mrst_n;
  logic         p0_req, p0_rd_bwt, p1_req, p1_rd_bwt;
  logic [31:0]  p0_addr, p1_addr;
  logic [15:0]  p0_wmask, p1_wmask;
  logic [127:0] p0_wdata, p1_wdata;
  logic         p0_ack, p0_rvalid, p1_ack, p1_rvalid;
  logic [127:0] p0_rdata, p1_rdata;
  logic         req_wen, req_wrd_bwt, req_wqfull;
  logic [31:0]  req_waddr;
  logic         wdq_wen, wdq_wqfull;
  logic [143:0] wdq_mask_wdata;
  logic         rdq_rnext, rdq_rqempty;
  logic [127:0] rdq_rdata;
  logic         arb_err;

  mig_req_arb #(.TAG_DEPTH(8), .TAG_AW(3)) dut (
    .mclk(mclk), .mrst_n(mrst_n),
    .p0_req(p0_req), .p0_rd_bwt(p0_rd_bwt), .p0_addr(p0_addr), .p0_wmask(p0_wmask),
    .p0_wdata(p0_wdata), .p0_ack(p0_ack), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_rd_bwt(p1_rd_bwt), .p1_addr(p1_addr), .p1_wmask(p1_wmask),
    .p1_wdata(p1_wdata), .p1_ack(p1_ack), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .req_wen(req_wen), .req_waddr(req_waddr), .req_wrd_bwt(req_wrd_bwt), .req_wqfull(req_wqfull),
    .wdq_wen(wdq_wen), .wdq_mask_wdata(wdq_mask_wdata), .wdq_wqfull(wdq_wqfull),
    .rdq_rnext(rdq_rnext), .rdq_rqempty(rdq_rqempty), .rdq_rdata(rdq_rdata), .arb_err(arb_err)
  );

  always #5 mclk = ~mclk;

  typedef struct { int port; logic rd; logic [31:0] addr; logic [15:0] mask; logic [127:0] data; } req_t;
  typedef struct { int port; logic [127:0] data; } ret_t;
  typedef struct { logic rnext; logic err; } cyc_t;

  req_t req_q[$];
  ret_t ret_q[$];
  cyc_t cyc_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: pending port commands, outstanding read owners, rdq contents.
  logic         pc_req[2];
  logic         pc_rd[2];
  logic [31:0]  pc_addr[2];
  logic [15:0]  pc_mask[2];
  logic [127:0] pc_data[2];
  int           m_tags[$];
  logic [127:0] rdq_q[$];
  int           m_last;
  logic         m_err;
  int           gen_mode;
  logic         rnd_full, rnd_ret, f_rq, f_wq;

  task automatic chk(input string nm, input logic [143:0] act, input logic [143:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic new_cmd(input int p);
    pc_mask[p] = 16'($urandom());
    pc_data[p] = rand128();
    pc_addr[p] = $urandom();
    if (gen_mode == 0) begin
      pc_req[p] = 1'b0;
    end else if (gen_mode == 1) begin
      pc_req[p] = 1'b1;
      pc_rd[p]  = 1'b0;
    end else begin
      pc_req[p] = ($urandom % 4 != 0);
      pc_rd[p]  = 1'($urandom % 2);
    end
  endtask

  task automatic set_cmd(input int p, input logic rd, input logic [31:0] a);
    pc_req[p]  = 1'b1;
    pc_rd[p]   = rd;
    pc_addr[p] = a;
    pc_mask[p] = 16'($urandom());
    pc_data[p] = rand128();
  endtask

  task automatic drive_ports();
    p0_req = pc_req[0]; p0_rd_bwt = pc_rd[0]; p0_addr = pc_addr[0]; p0_wmask = pc_mask[0]; p0_wdata = pc_data[0];
    p1_req = pc_req[1]; p1_rd_bwt = pc_rd[1]; p1_addr = pc_addr[1]; p1_wmask = pc_mask[1]; p1_wdata = pc_data[1];
  endtask

  // One clock cycle: drive inputs at the falling edge, predict the outcome, advance the model.
  task automatic cycle();
    int cnt, g, t;
    logic el[2];
    logic pop;
    logic [127:0] d;
    if (gen_mode == 2) begin
      for (int p = 0; p < 2; p++) if (!pc_req[p] && ($urandom % 2 == 0)) new_cmd(p);
    end
    if (rnd_full) begin
      f_rq = ($urandom % 5 == 0);
      f_wq = ($urandom % 5 == 0);
    end
    drive_ports();
    req_wqfull  = f_rq;
    wdq_wqfull  = f_wq;
    rdq_rqempty = (rdq_q.size() == 0);
    rdq_rdata   = (rdq_q.size() == 0) ? rand128() : rdq_q[0];

    cnt = m_tags.size();
    for (int p = 0; p < 2; p++)
      el[p] = pc_req[p] && !f_rq && (pc_rd[p] ? (cnt < 8) : !f_wq);
    if (el[0] && el[1]) g = 1 - m_last;
    else if (el[0])     g = 0;
    else if (el[1])     g = 1;
    else                g = -1;
    if (g >= 0) req_q.push_back('{g, pc_rd[g], pc_addr[g], pc_mask[g], pc_data[g]});

    pop = (rdq_q.size() != 0);
    cyc_q.push_back('{pop, m_err});
    if (pop) begin
      d = rdq_q.pop_front();
      if (cnt != 0) begin
        t = m_tags.pop_front();
        ret_q.push_back('{t, d});
      end else begin
        m_err = 1'b1;
      end
    end
    if (g >= 0) begin
      if (pc_rd[g]) m_tags.push_back(g);
      m_last = g;
      new_cmd(g);
    end
    if (rnd_ret && (m_tags.size() > rdq_q.size()) && ($urandom % 3 == 0)) rdq_q.push_back(rand128());
    @(negedge mclk);
  endtask

  task automatic do_reset();
    mrst_n = 1'b0;
    pc_req[0] = 1'b0;
    pc_req[1] = 1'b0;
    drive_ports();
    m_tags.delete();
    ret_q.delete();
    m_last = 1;
    m_err  = 1'b0;
    repeat (2) @(negedge mclk);
    mrst_n = 1'b1;
  endtask

  // Return every outstanding read and let the last rvalid drain.
  task automatic drain();
    gen_mode = 0;
    rnd_full = 1'b0;
    f_rq = 1'b0;
    f_wq = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (!pc_req[0] && !pc_req[1] && m_tags.size() == 0 && rdq_q.size() == 0) break;
      if (m_tags.size() > rdq_q.size()) rdq_q.push_back(rand128());
      cycle();
    end
    repeat (2) cycle();
  endtask

  // Monitor: compares DUT activity against queued expectations, mid-cycle.
  logic [127:0] hold[2];
  initial begin
    req_t r;
    ret_t q;
    cyc_t c;
    int rp;
    hold[0] = '0;
    hold[1] = '0;
    forever begin
      @(negedge mclk);
      #2;
      if (!mrst_n) begin
        hold[0] = '0;
        hold[1] = '0;
      end else begin
        if (req_wen || wdq_wen || p0_ack || p1_ack) begin
          if (req_q.size() == 0) begin
            chk("unexpected_grant", 144'(req_wen), 144'(0));
          end else begin
            r = req_q.pop_front();
            chk("p0_ack", 144'(p0_ack), 144'(r.port == 0));
            chk("p1_ack", 144'(p1_ack), 144'(r.port == 1));
            chk("req_wen", 144'(req_wen), 144'(1));
            chk("req_waddr", 144'(req_waddr), 144'(r.addr));
            chk("req_wrd_bwt", 144'(req_wrd_bwt), 144'(r.rd));
            chk("wdq_wen", 144'(wdq_wen), 144'(!r.rd));
            if (!r.rd) chk("wdq_mask_wdata", wdq_mask_wdata, {r.mask, r.data});
          end
        end
        if (cyc_q.size() != 0) begin
          c = cyc_q.pop_front();
          chk("rdq_rnext", 144'(rdq_rnext), 144'(c.rnext));
          chk("arb_err", 144'(arb_err), 144'(c.err));
        end
        if (p0_rvalid && p1_rvalid) chk("dual_rvalid", 144'(1), 144'(0));
        if (p0_rvalid || p1_rvalid) begin
          rp = p1_rvalid ? 1 : 0;
          if (ret_q.size() == 0) begin
            chk("unexpected_rvalid", 144'(1), 144'(0));
          end else begin
            q = ret_q.pop_front();
            chk("rvalid_port", 144'(rp), 144'(q.port));
            chk("rdata", 144'(rp ? p1_rdata : p0_rdata), 144'(q.data));
            hold[q.port] = q.data;
          end
        end
        if (!p0_rvalid) chk("p0_rdata_hold", 144'(p0_rdata), 144'(hold[0]));
        if (!p1_rvalid) chk("p1_rdata_hold", 144'(p1_rdata), 144'(hold[1]));
      end
    end
  end

  initial begin
    gen_mode = 0; rnd_full = 1'b0; rnd_ret = 1'b0; f_rq = 1'b0; f_wq = 1'b0;
    m_last = 1; m_err = 1'b0;
    for (int p = 0; p < 2; p++) begin
      pc_req[p] = 1'b0; pc_rd[p] = 1'b0; pc_addr[p] = '0; pc_mask[p] = '0; pc_data[p] = '0;
    end
    // Reset state, with active-looking inputs that must be ignored.
    mrst_n = 1'b0;
    set_cmd(0, 1'b0, 32'h40);
    set_cmd(1, 1'b1, 32'h80);
    drive_ports();
    req_wqfull = 1'b0; wdq_wqfull = 1'b0; rdq_rqempty = 1'b0; rdq_rdata = rand128();
    #2;
    chk("rst_p0_ack", 144'(p0_ack), 144'(0));
    chk("rst_p1_ack", 144'(p1_ack), 144'(0));
    chk("rst_req_wen", 144'(req_wen), 144'(0));
    chk("rst_wdq_wen", 144'(wdq_wen), 144'(0));
    chk("rst_rdq_rnext", 144'(rdq_rnext), 144'(0));
    chk("rst_p0_rvalid", 144'(p0_rvalid), 144'(0));
    chk("rst_p1_rvalid", 144'(p1_rvalid), 144'(0));
    chk("rst_p0_rdata", 144'(p0_rdata), 144'(0));
    chk("rst_p1_rdata", 144'(p1_rdata), 144'(0));
    chk("rst_arb_err", 144'(arb_err), 144'(0));
    pc_req[0] = 1'b0; pc_req[1] = 1'b0;
    drive_ports();
    rdq_rqempty = 1'b1;
    @(negedge mclk);
    mrst_n = 1'b1;

    // Single read on port 0, data returned two cycles later.
    set_cmd(0, 1'b1, 32'h0000_0100);
    cycle();
    cycle();
    rdq_q.push_back({16{8'hA5}});
    repeat (3) cycle();

    // Contention: both ports writing continuously from reset.
    do_reset();
    gen_mode = 1;
    set_cmd(0, 1'b0, 32'h1000);
    set_cmd(1, 1'b0, 32'h2000);
    repeat (10) cycle();
    drain();

    // Interleaved reads p0, p1, p0 with in-order returns.
    set_cmd(0, 1'b1, 32'h300); cycle();
    set_cmd(1, 1'b1, 32'h310); cycle();
    set_cmd(0, 1'b1, 32'h320); cycle();
    for (int i = 0; i < 3; i++) rdq_q.push_back(rand128());
    repeat (5) cycle();

    // Backpressure: wdq full holds the write while the read proceeds.
    f_wq = 1'b1;
    set_cmd(0, 1'b0, 32'h400);
    set_cmd(1, 1'b1, 32'h410);
    repeat (3) cycle();
    f_wq = 1'b0;
    repeat (2) cycle();
    drain();

    // Tag full: eight reads outstanding block the ninth until one returns.
    for (int i = 0; i < 8; i++) begin
      set_cmd(0, 1'b1, 32'h500 + 32'(i * 16));
      cycle();
    end
    set_cmd(1, 1'b1, 32'h600);
    repeat (3) cycle();
    rdq_q.push_back(rand128());
    repeat (3) cycle();
    set_cmd(0, 1'b1, 32'h700);
    repeat (3) cycle();
    drain();

    // Reset with reads outstanding, then an orphan rdq entry.
    for (int i = 0; i < 3; i++) begin
      set_cmd(i % 2, 1'b1, 32'h800 + 32'(i * 16));
      cycle();
    end
    do_reset();
    rdq_q.push_back(rand128());
    repeat (5) cycle();

    // Randomized traffic with random backpressure and return timing.
    do_reset();
    gen_mode = 2; rnd_full = 1'b1; rnd_ret = 1'b1;
    repeat (3000) cycle();
    rnd_ret = 1'b0;
    drain();

    chk("req_q_empty", 144'(req_q.size()), 144'(0));
    chk("ret_q_empty", 144'(ret_q.size()), 144'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
